// File: rtl/ram_filler_pkg.sv
// Shared types and constants for the ram_filler fill engine:
// FSM states, fill-mode encodings and the 16-bit LFSR definition.
package ram_filler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] FILL_CONST = 2'd0;
  localparam logic [1:0] FILL_INC   = 2'd1;
  localparam logic [1:0] FILL_ADDR  = 2'd2;
  localparam logic [1:0] FILL_LFSR  = 2'd3;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // All-zero is the lock-up state of the LFSR, so it is never used as a seed
  function automatic logic [15:0] lfsr_seed(input logic [15:0] p);
    logic [15:0] s;
    s = LFSR_SEED ^ p;
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/ram_filler_pattern.sv
// fill_pattern_gen: produces the current fill word from the latched mode/pattern.
// The LFSR register exists only when RAM_FILLER_LFSR_EN is defined; otherwise
// mode 3 falls back to the constant pattern.
module fill_pattern_gen
  import ram_filler_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] pos,      // low bits of the current write address
  input  logic              load,     // latch mode/pattern, restart sequences
  input  logic              step,     // current word accepted, advance
  output logic [DATA_W-1:0] data
);

  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] inc_q;

  // Latch configuration on load; incrementing word advances per accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= FILL_CONST;
      pat_q  <= '0;
      inc_q  <= '0;
    end else if (load) begin
      mode_q <= mode;
      pat_q  <= pattern;
      inc_q  <= pattern;
    end else if (step) begin
      inc_q  <= inc_q + 1'b1;
    end
  end

`ifdef RAM_FILLER_LFSR_EN
  logic [15:0] lfsr_q;

  // LFSR reseeds on load and steps once per accepted word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  lfsr_q <= LFSR_SEED;
    else if (load) lfsr_q <= lfsr_seed(16'(pattern));
    else if (step) lfsr_q <= lfsr_next(lfsr_q);
  end
`endif

  // Select the word for the current address
  always_comb begin
    data = pat_q;
    case (mode_q)
      FILL_INC:  data = inc_q;
      FILL_ADDR: data = pos;
`ifdef RAM_FILLER_LFSR_EN
      FILL_LFSR: data = lfsr_q[DATA_W-1:0];
`endif
      default:   data = pat_q;
    endcase
  end

endmodule

// File: rtl/ram_filler.sv
// ram_filler: fills [start_addr, end_addr) of SDRAM, one word per write ack.
// Optional feature: RAM_FILLER_LFSR_EN enables the pseudo-random mode 3.
module ram_filler
  import ram_filler_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic              trigger,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] pattern,
  input  logic [1:0]        mode,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              load, step;

  // State and address registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      end_q   <= end_d;
    end
  end

  // Next state; abort wins over a same-cycle ack so that word is not counted
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    end_d   = end_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (ena && trigger) begin
        load  = 1'b1;
        end_d = end_addr;
        if (start_addr < end_addr) begin
          state_d = WRITE;
          pos_d   = start_addr;
        end else begin
          state_d = DONE;
        end
      end
      WRITE: if (ena) begin
        if (abort) begin
          state_d = IDLE;
        end else if (ack) begin
          step = 1'b1;
          if (pos_q == end_q - ADDR_W'(1)) state_d = DONE;
          else                             pos_d   = pos_q + ADDR_W'(1);
        end
      end
      DONE: if (ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  fill_pattern_gen #(.DATA_W(DATA_W)) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .pattern (pattern),
    .pos     (pos_q[DATA_W-1:0]),
    .load    (load),
    .step    (step),
    .data    (data)
  );

  assign busy = (state_q == WRITE);
  assign wr   = (state_q == WRITE);
  assign done = (state_q == DONE);
  assign addr = pos_q;

endmodule

// File: tb/tb_ram_filler.sv
// Directed self-checking bench for ram_filler (ADDR_W=25, DATA_W=8).
// Honours RAM_FILLER_LFSR_EN for the mode-3 expectations.
module tb_ram_filler;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n, ena, trigger, abort, ack;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [DATA_W-1:0] pattern;
  logic [1:0]        mode;
  logic              busy, done, wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  int n_chk = 0;
  int n_err = 0;

  ram_filler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .trigger(trigger), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .pattern(pattern), .mode(mode),
    .ack(ack), .busy(busy), .done(done), .wr(wr), .addr(addr), .data(data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                      input logic [1:0] m, input logic [DATA_W-1:0] p);
    start_addr = s; end_addr = e; mode = m; pattern = p;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        exp_bp [4];
  logic [7:0]        exp_lf [4];
  int                n;

  initial begin
    reset_n = 1'b0; ena = 1'b1; trigger = 1'b0; abort = 1'b0; ack = 1'b0;
    start_addr = '0; end_addr = '0; pattern = '0; mode = 2'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr",   32'(wr),   0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    reset_n = 1'b1;
    tick();

    // Erase tail of legacy range with constant 0xFF, ack tied high
    ack = 1'b1;
    fire(25'h1FF00, 25'h20000, 2'd0, 8'hFF);
    chk("erase_first_wr",   32'(wr),   1);
    chk("erase_first_busy", 32'(busy), 1);
    exp_addr = 25'h1FF00;
    n = 0;
    while (wr && n < 1000) begin
      chk("erase_addr", 32'(addr), 32'(exp_addr));
      chk("erase_data", 32'(data), 32'hFF);
      exp_addr++;
      n++;
      tick();
    end
    chk("erase_count", n, 256);
    chk("erase_done",  32'(done), 1);
    chk("erase_busy",  32'(busy), 0);
    tick();
    chk("erase_done_clr", 32'(done), 0);

    // Back-pressure: ack every third cycle, incrementing from 0xFE
    ack = 1'b0;
    exp_bp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    fire(25'h100, 25'h104, 2'd1, 8'hFE);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        ack = (c == 2);
        chk("bp_wr",   32'(wr),   1);
        chk("bp_addr", 32'(addr), 32'h100 + k);
        chk("bp_data", 32'(data), 32'(exp_bp[k]));
        tick();
      end
    end
    ack = 1'b0;
    chk("bp_done", 32'(done), 1);
    chk("bp_wr_off", 32'(wr), 0);
    tick();

    // Abort after 10 accepted words; same-cycle ack must not count
    ack = 1'b1;
    fire(25'h0, 25'h1000, 2'd0, 8'h33);
    repeat (10) tick();
    chk("abort_pos", 32'(addr), 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wr",   32'(wr),   0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    tick();
    chk("abort_done2", 32'(done), 0);
    fire(25'h20, 25'h22, 2'd0, 8'h44);
    chk("retrig_wr",   32'(wr),   1);
    chk("retrig_addr", 32'(addr), 32'h20);
    tick();
    tick();
    chk("retrig_done", 32'(done), 1);
    tick();

    // Empty range goes straight to DONE
    ack = 1'b0;
    fire(25'h500, 25'h500, 2'd0, 8'h11);
    chk("empty_done", 32'(done), 1);
    chk("empty_wr",   32'(wr),   0);
    chk("empty_busy", 32'(busy), 0);
    tick();
    chk("empty_done_clr", 32'(done), 0);

    // Trigger while running is ignored
    fire(25'h300, 25'h303, 2'd1, 8'h10);
    fire(25'h700, 25'h7FF, 2'd0, 8'h99);
    chk("ign_addr", 32'(addr), 32'h300);
    chk("ign_data", 32'(data), 32'h10);
    ack = 1'b1;
    tick();
    chk("ign_addr2", 32'(addr), 32'h301);
    chk("ign_data2", 32'(data), 32'h11);
    tick();
    tick();
    chk("ign_done", 32'(done), 1);
    tick();

    // ena gating with address-derived data
    fire(25'h1F0, 25'h210, 2'd2, 8'h00);
    exp_addr = 25'h1F0;
    n = 0;
    while (wr && n < 200) begin
      ena = n[0];
      chk("ena_addr", 32'(addr), 32'(exp_addr));
      chk("ena_data", 32'(data), 32'(exp_addr[7:0]));
      if (ena) exp_addr++;
      n++;
      tick();
    end
    chk("ena_end",  32'(exp_addr), 32'h210);
    chk("ena_done", 32'(done), 1);
    ena = 1'b0;
    tick();
    chk("ena_done_hold", 32'(done), 1);
    ena = 1'b1;
    tick();
    chk("ena_done_clr", 32'(done), 0);

    // Asynchronous reset in the middle of a fill
    fire(25'h40, 25'h80, 2'd0, 8'hAA);
    repeat (3) tick();
    chk("pre_rst_addr", 32'(addr), 32'h43);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_wr",   32'(wr),   0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_data", 32'(data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_wr",   32'(wr),   0);

    // Mode 3
`ifdef RAM_FILLER_LFSR_EN
    exp_lf = '{8'hE1, 8'h70, 8'h38, 8'h9C};
    fire(25'h0, 25'h4, 2'd3, 8'h00);
`else
    exp_lf = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
    fire(25'h0, 25'h4, 2'd3, 8'h5A);
`endif
    for (int k = 0; k < 4; k++) begin
      chk("m3_data", 32'(data), 32'(exp_lf[k]));
      tick();
    end
    chk("m3_done", 32'(done), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ram_filler.md
# ram_filler

Parametrised memory fill engine for the SDRAM write port. It is the successor to the fixed cold-boot RAM eraser. On a trigger it writes a run-time-selected address range with a constant, incrementing, address-derived or pseudo-random pattern, one word per SDRAM write acknowledge. It sits between the boot/reset controller and the SDRAM arbiter's write channel, and reports busy/done to the controller.

## Interface
- ADDR_W, 25, width of SDRAM address bus
- DATA_W, 8, width of write data (1..16)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; all state advances only when high
- trigger  in  1  start a fill; sampled when ena=1 in IDLE
- abort  in  1  cancel a running fill; sampled when ena=1
- start_addr  in  ADDR_W  first address (inclusive), latched on trigger
- end_addr  in  ADDR_W  last address + 1 (exclusive), latched on trigger
- pattern  in  DATA_W  base fill value / seed, latched on trigger
- mode  in  2  0=constant, 1=incrementing, 2=address low bits, 3=LFSR; latched on trigger
- ack  in  1  SDRAM write accepted for current addr/data
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse on normal completion
- wr  out  1  write request; held until ack
- addr  out  ADDR_W  write address
- data  out  DATA_W  write data

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: trigger&ena latches all inputs.
  - If start_addr < end_addr: go to WRITE with pos=start_addr.
  - Else (empty range): go straight to DONE.
- WRITE: wr=1, addr=pos, data=current word.
  - On ack&ena with pos==end-1: go to DONE.
  - On ack&ena otherwise: pos+1 and next word, staying in WRITE with wr continuously high.
- DONE: done=1 for one cycle, then IDLE.
- abort&ena in WRITE: go to IDLE next cycle with wr=0. No done pulse. Abort takes priority over a same-cycle ack; the word counts as not written.
- trigger while not IDLE: ignored.
- Data words, index i = pos - start (all arithmetic modulo 2^DATA_W):
  - mode 0: pattern.
  - mode 1: pattern + i.
  - mode 2: pos[DATA_W-1:0].
  - mode 3: LFSR output, see Configuration.
- pos width ADDR_W. Compares are unsigned. end_addr = 2^ADDR_W is not representable, so the top address cannot be included.
- ena=0: outputs and state hold. ack is ignored.

## Timing
- Reset values: busy=0, done=0, wr=0, addr=0, data=0; state IDLE.
- Trigger sampled at edge N. At N+1: wr=1, addr=start_addr, busy=1.
- Throughput: one word per ack cycle. With ack tied high and ena=1, a range of L words takes L cycles of wr.
- Last ack at edge M. At M+1: wr=0, busy=0, done=1. At M+2: done=0.
- Empty range: done pulses at N+1. busy and wr stay 0.
- addr/data are stable from wr assertion until the accepting ack edge.
- reset_n low mid-fill: immediate return to reset values. No done pulse.

## Configuration
- RAM_FILLER_LFSR_EN defined:
  - mode 3 uses a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  - Seed is 16'hACE1 XOR zero-extended pattern; a zero seed is forced to 16'h0001.
  - The LFSR steps once per accepted word.
  - data is LFSR[DATA_W-1:0].
- RAM_FILLER_LFSR_EN undefined: no LFSR logic; mode 3 behaves as mode 0.

## Structure
- Shared package ram_filler_pkg holds:
  - state enum (IDLE, WRITE, DONE)
  - mode encodings (FILL_CONST, FILL_INC, FILL_ADDR, FILL_LFSR)
  - LFSR polynomial taps, seed constant 16'hACE1
- Sub-module fill_pattern_gen (mode, pattern, pos, load, step -> data) isolates pattern/LFSR logic from the FSM.

## Test plan
- Legacy erase: start=0x0C000, end=0x20000, mode 0, pattern 0xFF, ack=1 -> 0x14000 writes of 0xFF. Last addr 0x1FFFF; done one cycle after.
- Back-pressure: start=0x100, end=0x104, mode 1, pattern 0xFE, ack every 3rd cycle -> data FE,FF,00,01 at 0x100..0x103. addr/data hold between acks.
- Abort: start=0, end=0x1000, abort after 10 acks -> wr=0 next cycle, busy=0, no done. A re-trigger is accepted afterwards.
- Empty range and retrigger: start=end=0x500 -> done at N+1, no wr. A trigger pulsed during a running fill changes nothing.
- ena gating and reset: ena toggled 50%, mode 2, start=0x1F0, end=0x210 -> data equals addr[7:0]; nothing advances while ena=0. reset_n low mid-fill -> all outputs 0 immediately.
- LFSR (macro on): mode 3, pattern 0x00 -> first data 0xE1, then the correct next LFSR values. Macro off: mode 3 with pattern 0x5A -> all 0x5A.
